// File: rtl/clk_pkg.sv
// Shared definitions for the slow-clock divider/monitor pair: FSM states and
// default clock rates used to derive the expected slow-clock period.
package clk_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACQ  = 2'd1,
    LOCK = 2'd2
  } state_t;

  localparam int unsigned SYS_CLK_HZ  = 100_000_000;
  localparam int unsigned SLOW_CLK_HZ = 10;

  // Slow-clock period expressed in system clock cycles.
  function automatic int unsigned calc_exp_period(input int unsigned sys_hz,
                                                  input int unsigned slow_hz);
    return sys_hz / slow_hz;
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchroniser with registered rising-edge pulse. Defining
// SLOWCLK_FILTER_EN inserts a 3-sample glitch filter ahead of the edge detect.
module sync_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic tick,
  output logic rise_c
);

  logic s1;
  logic s2;
  logic hist;

`ifdef SLOWCLK_FILTER_EN
  logic h1;
  logic h2;
  logic filt_c;

  // Filtered level follows s2 only once three consecutive samples agree.
  always_comb begin
    filt_c = hist;
    if ((s2 == h1) && (h1 == h2)) begin
      filt_c = s2;
    end
    rise_c = filt_c & ~hist;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      h1   <= 1'b0;
      h2   <= 1'b0;
      hist <= 1'b0;
      tick <= 1'b0;
    end else begin
      s1   <= din;
      s2   <= s1;
      h1   <= s2;
      h2   <= h1;
      hist <= filt_c;
      tick <= rise_c;
    end
  end
`else
  always_comb begin
    rise_c = s2 & ~hist;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      hist <= 1'b0;
      tick <= 1'b0;
    end else begin
      s1   <= din;
      s2   <= s1;
      hist <= s2;
      tick <= rise_c;
    end
  end
`endif

endmodule

// File: rtl/slowclk_monitor.sv
// Slow-clock monitor: TICK per synchronised rising edge, period measurement and
// lock tracking. SLOWCLK_FILTER_EN enables the input glitch filter.
module slowclk_monitor
  import clk_pkg::*;
#(
  parameter int unsigned EXP_PERIOD = calc_exp_period(SYS_CLK_HZ, SLOW_CLK_HZ),
  parameter int unsigned TOL        = 100000,
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned CNT_W      = 24
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             SLOWCLK,
  output logic             TICK,
  output logic             LOCKED,
  output logic             LOST,
  output logic [CNT_W-1:0] PERIOD,
  output logic [7:0]       ERR_CNT
);

  localparam int unsigned GOOD_W = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0]  PER_MIN   = CNT_W'(EXP_PERIOD - TOL);
  localparam logic [CNT_W-1:0]  PER_MAX   = CNT_W'(EXP_PERIOD + TOL);
  localparam logic [CNT_W-1:0]  TIMEOUT   = CNT_W'(EXP_PERIOD + TOL + 1);
  localparam logic [GOOD_W-1:0] GOOD_LOCK = GOOD_W'(LOCK_COUNT);

  state_t             state;
  state_t             state_d;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_d;
  logic [CNT_W-1:0]   cnt_plus;
  logic [CNT_W-1:0]   period_d;
  logic [GOOD_W-1:0]  good;
  logic [GOOD_W-1:0]  good_d;
  logic [GOOD_W-1:0]  good_inc;
  logic [7:0]         err_d;
  logic               locked_d;
  logic               lost_d;
  logic               rise_c;
  logic               in_tol;
  logic               timeout;
  logic               bad;

  sync_edge_det u_sync (
    .clk    (CLK),
    .rst    (RESET),
    .din    (SLOWCLK),
    .tick   (TICK),
    .rise_c (rise_c)
  );

  // cnt_plus is the elapsed period if an edge lands this cycle.
  always_comb begin
    cnt_plus = (cnt == '1) ? cnt : cnt + CNT_W'(1);
    good_inc = good + GOOD_W'(1);
    in_tol   = (cnt_plus >= PER_MIN) && (cnt_plus <= PER_MAX);
    timeout  = (cnt_plus == TIMEOUT);
  end

  // Next-state, lock tracking and error accounting.
  always_comb begin
    state_d  = state;
    cnt_d    = cnt_plus;
    period_d = PERIOD;
    good_d   = good;
    locked_d = LOCKED;
    lost_d   = 1'b0;
    err_d    = ERR_CNT;
    bad      = 1'b0;

    if (rise_c) begin
      cnt_d    = '0;
      period_d = cnt_plus;
    end

    case (state)
      IDLE: begin
        if (rise_c) begin
          state_d = ACQ;
          good_d  = '0;
        end
      end
      ACQ: begin
        if (rise_c) begin
          if (in_tol) begin
            good_d = good_inc;
            if (good_inc == GOOD_LOCK) begin
              state_d  = LOCK;
              locked_d = 1'b1;
            end
          end else begin
            bad = 1'b1;
          end
        end else if (timeout) begin
          bad   = 1'b1;
          cnt_d = '0;
        end
      end
      LOCK: begin
        if (rise_c) begin
          bad = ~in_tol;
        end else if (timeout) begin
          bad   = 1'b1;
          cnt_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Edge-wins priority is implicit: timeout is only considered without an edge.
    if (bad) begin
      good_d = '0;
      err_d  = (ERR_CNT == 8'hFF) ? ERR_CNT : ERR_CNT + 8'd1;
      if (state == LOCK) begin
        state_d  = ACQ;
        locked_d = 1'b0;
        lost_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state   <= IDLE;
      cnt     <= '0;
      good    <= '0;
      LOCKED  <= 1'b0;
      LOST    <= 1'b0;
      PERIOD  <= '0;
      ERR_CNT <= 8'd0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      good    <= good_d;
      LOCKED  <= locked_d;
      LOST    <= lost_d;
      PERIOD  <= period_d;
      ERR_CNT <= err_d;
    end
  end

endmodule

// File: tb/tb_slowclk_monitor.sv
// Bench for slowclk_monitor: cycle-stamp reference model compared every cycle,
// plus directed literal checks. Honours SLOWCLK_FILTER_EN when defined.
module tb_slowclk_monitor;

  localparam int EXP = 20;
  localparam int TOL = 2;
  localparam int LC  = 4;
  localparam int TO  = EXP + TOL + 1;
`ifdef SLOWCLK_FILTER_EN
  localparam int LAT        = 5;
  localparam int GLITCH_TKS = 0;
`else
  localparam int LAT        = 3;
  localparam int GLITCH_TKS = 1;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       slow;
  logic       tick;
  logic       locked;
  logic       lost;
  logic [7:0] period;
  logic [7:0] err_cnt;

  slowclk_monitor #(
    .EXP_PERIOD (EXP),
    .TOL        (TOL),
    .LOCK_COUNT (LC),
    .CNT_W      (8)
  ) dut (
    .CLK     (clk),
    .RESET   (rst),
    .SLOWCLK (slow),
    .TICK    (tick),
    .LOCKED  (locked),
    .LOST    (lost),
    .PERIOD  (period),
    .ERR_CNT (err_cnt)
  );

  initial forever #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: cycle stamps of the last edge/timeout, a sample history
  // of SLOWCLK, and counts of consecutive good periods.
  int k = 0;
  int mark = 0;
  int good = 0;
  int lvl = 0;
  bit seen = 1'b0;
  bit m_locked = 1'b0;
  bit m_tick = 1'b0;
  bit m_lost = 1'b0;
  int m_period = 0;
  int m_err = 0;
  bit h [5];

  initial begin
    forever begin
      bit ev;
      bit ok;
      bit bad;
      int gap;
      @(posedge clk);
      k++;
      if (rst) begin
        mark = k; seen = 0; good = 0; lvl = 0;
        m_locked = 0; m_tick = 0; m_lost = 0; m_period = 0; m_err = 0;
        for (int i = 0; i < 5; i++) h[i] = 1'b0;
      end else begin
        for (int i = 4; i > 0; i--) h[i] = h[i-1];
        h[0] = slow;
`ifdef SLOWCLK_FILTER_EN
        ev = 1'b0;
        if (h[2] == h[3] && h[3] == h[4] && int'(h[2]) != lvl) begin
          lvl = int'(h[2]);
          ev  = h[2];
        end
`else
        ev = h[2] && !h[3];
`endif
        m_tick = ev;
        m_lost = 1'b0;
        gap = k - mark;
        ok  = 1'b0;
        bad = 1'b0;
        if (ev) begin
          m_period = (gap > 255) ? 255 : gap;
          mark = k;
          if (!seen) begin
            seen = 1'b1;
            good = 0;
          end else if (gap >= EXP - TOL && gap <= EXP + TOL) ok = 1'b1;
          else bad = 1'b1;
        end else if (seen && gap == TO) begin
          bad  = 1'b1;
          mark = k;
        end
        if (ok && !m_locked) begin
          good++;
          if (good == LC) m_locked = 1'b1;
        end
        if (bad) begin
          good = 0;
          if (m_err < 255) m_err++;
          if (m_locked) begin
            m_locked = 1'b0;
            m_lost   = 1'b1;
          end
        end
      end
    end
  end

  bit cmp_en = 1'b0;
  int tick_cnt = 0;
  int lost_cnt = 0;

  // Compare DUT against the model every cycle, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        check("tick",    32'(tick),    32'(m_tick));
        check("locked",  32'(locked),  32'(m_locked));
        check("lost",    32'(lost),    32'(m_lost));
        check("period",  32'(period),  32'(m_period));
        check("err_cnt", 32'(err_cnt), 32'(m_err));
        if (tick === 1'b1) tick_cnt++;
        if (lost === 1'b1) lost_cnt++;
      end
    end
  end

  task automatic per(input int p);
    slow = 1'b1;
    repeat (p / 2) @(negedge clk);
    slow = 1'b0;
    repeat (p - p / 2) @(negedge clk);
  endtask

  initial begin
    int t0;
    int l0;
    int lat;
    rst  = 1'b1;
    slow = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tick",   32'(tick),    0);
    check("rst_locked", 32'(locked),  0);
    check("rst_lost",   32'(lost),    0);
    check("rst_period", 32'(period),  0);
    check("rst_err",    32'(err_cnt), 0);
    cmp_en = 1'b1;
    rst    = 1'b0;

    // Clean 20-cycle square wave: lock after the 5th edge.
    repeat (6) per(20);
    check("sq_ticks",  tick_cnt, 6);
    check("sq_locked", 32'(locked), 1);
    check("sq_period", 32'(period), 20);
    check("sq_err",    32'(err_cnt), 0);
    check("sq_lost",   lost_cnt, 0);

    // One 23-cycle period (edge coincides with timeout threshold, edge wins).
    per(23);
    per(20);
    check("long_locked", 32'(locked), 0);
    check("long_lost",   lost_cnt, 1);
    check("long_err",    32'(err_cnt), 1);
    check("long_period", 32'(period), 23);
    repeat (3) per(20);
    check("relock_early", 32'(locked), 0);
    per(20);
    check("relock", 32'(locked), 1);

    // Boundaries: 18 and 22 good, 17 and 23 bad.
    per(18); per(22); per(20);
    check("bound_good_locked", 32'(locked), 1);
    check("bound_good_err",    32'(err_cnt), 1);
    per(17); per(20);
    check("short_locked", 32'(locked), 0);
    check("short_err",    32'(err_cnt), 2);
    check("short_lost",   lost_cnt, 2);
    per(20); per(20); per(23); per(20);
    check("gcnt_reset_err", 32'(err_cnt), 3);
    repeat (3) per(20);
    check("gcnt_reset_locked", 32'(locked), 0);
    per(20);
    check("gcnt_relock", 32'(locked), 1);
    check("gcnt_lost", lost_cnt, 2);

    // SLOWCLK stops: three timeouts, one LOST, no TICK.
    t0 = tick_cnt;
    repeat (60) @(negedge clk);
    check("to_err",    32'(err_cnt), 6);
    check("to_lost",   lost_cnt, 3);
    check("to_locked", 32'(locked), 0);
    check("to_ticks",  tick_cnt, t0);
    check("to_period", 32'(period), 20);

    // Relock, then a one-cycle reset.
    repeat (6) per(20);
    check("pre_rst_locked", 32'(locked), 1);
    check("pre_rst_err",    32'(err_cnt), 7);
    l0  = lost_cnt;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rst_locked", 32'(locked), 0);
    check("mid_rst_period", 32'(period), 0);
    check("mid_rst_err",    32'(err_cnt), 0);
    check("mid_rst_tick",   32'(tick), 0);
    check("mid_rst_lost",   lost_cnt, l0);
    @(negedge clk);
    per(20); per(20);
    check("post_rst_err",    32'(err_cnt), 0);
    check("post_rst_locked", 32'(locked), 0);
    check("post_rst_period", 32'(period), 20);

    // Two-cycle glitch: filtered away only when the filter is built in.
    t0 = tick_cnt;
    slow = 1'b1;
    repeat (2) @(negedge clk);
    slow = 1'b0;
    repeat (20) @(negedge clk);
    check("glitch_ticks", tick_cnt - t0, GLITCH_TKS);

    // Clean edge latency in CLK edges from the first sampling edge.
    slow = 1'b1;
    lat  = 0;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk);
      #1;
      if (tick === 1'b1 && lat == 0) lat = n;
    end
    check("tick_latency", lat, LAT);
    @(negedge clk);
    slow = 1'b0;
    repeat (10) @(negedge clk);

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
